// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
// Shared definitions for the demux2way16_router block.
//   LANE_A / LANE_B : in_sel encodings (0 -> lane A, 1 -> lane B)
//   DATA_W          : default routed word width
//   lane_state_t    : per-lane FIFO occupancy state (EMPTY / PARTIAL / FULL)
// -----------------------------------------------------------------------------
package demux_pkg;

    localparam logic LANE_A = 1'b0;
    localparam logic LANE_B = 1'b1;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } lane_state_t;

endpackage : demux_pkg

// File: rtl/demux_lane_fifo.sv
// -----------------------------------------------------------------------------
// demux_lane_fifo
// Single output lane of the router: a small registered FIFO with a
// valid/ready output handshake. Owns storage, pointers, occupancy and the
// EMPTY/PARTIAL/FULL lane state.
//
// Ports
//   clk        in   1      rising-edge clock
//   reset_n    in   1      synchronous active-low reset; clears everything
//   push       in   1      write push_data to the tail (ignored when full)
//   push_data  in   WIDTH  word to enqueue
//   full       out  1      lane holds DEPTH words
//   valid      out  1      lane is non-empty
//   data       out  WIDTH  head word (0 after reset)
//   pop        in   1      consumer takes the head (ignored when empty)
// -----------------------------------------------------------------------------
module demux_lane_fifo
    import demux_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    input  logic             pop
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    lane_state_t      state;
    lane_state_t      state_next;
    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] occ_next;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    logic do_push;
    logic do_pop;

    // Qualify requests with the registered state so a caller can never
    // overflow or underflow the lane, whatever it drives.
    assign do_push = push & (state != ST_FULL);
    assign do_pop  = pop  & (state != ST_EMPTY);

    assign full  = (state == ST_FULL);
    assign valid = (state != ST_EMPTY);
    assign data  = mem[rd_ptr];

    // State / occupancy register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_EMPTY;
            occ   <= '0;
        end else begin
            state <= state_next;
            occ   <= occ_next;
        end
    end

    // Next-state: occupancy decides PARTIAL vs. the EMPTY/FULL boundaries.
    always_comb begin
        state_next = state;
        occ_next   = occ;
        unique case (state)
            ST_EMPTY: begin
                // valid=0 here, so a pop cannot coincide with a push.
                if (do_push) begin
                    occ_next   = occ + OCC_ONE;
                    state_next = (occ_next == OCC_FULL) ? ST_FULL : ST_PARTIAL;
                end
            end
            ST_PARTIAL: begin
                if (do_push && !do_pop) begin
                    occ_next   = occ + OCC_ONE;
                    state_next = (occ_next == OCC_FULL) ? ST_FULL : ST_PARTIAL;
                end else if (do_pop && !do_push) begin
                    occ_next   = occ - OCC_ONE;
                    state_next = (occ_next == '0) ? ST_EMPTY : ST_PARTIAL;
                end
            end
            ST_FULL: begin
                // Pushes are already masked off while full.
                if (do_pop) begin
                    occ_next   = occ - OCC_ONE;
                    state_next = ST_PARTIAL;
                end
            end
            default: begin
                occ_next   = '0;
                state_next = ST_EMPTY;
            end
        endcase
    end

    // Storage and pointers; pointers wrap modulo DEPTH (power of two).
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule : demux_lane_fifo

// File: rtl/demux2way16_router.sv
// -----------------------------------------------------------------------------
// demux2way16_router
// 1-to-2 demultiplexer for 16-bit words. Each accepted input word is steered
// to lane A (in_sel=0) or lane B (in_sel=1); every lane buffers in its own
// FIFO and offers words to its consumer over valid/ready. Words appear on a
// lane one cycle after acceptance; there is no input-to-output bypass.
//
// Optional feature: define DEMUX2WAY16_STATS_EN to add per-lane pop counters
// (a_count / b_count ports). Without it those ports and counters are absent.
//
// Ports
//   clk       in   1      rising-edge clock
//   reset_n   in   1      synchronous active-low reset
//   in_data   in   WIDTH  word to route
//   in_sel    in   1      0 -> lane A, 1 -> lane B
//   in_valid  in   1      producer offers in_data/in_sel
//   in_ready  out  1      selected lane can accept this cycle
//   a_data    out  WIDTH  lane A head word
//   a_valid   out  1      lane A non-empty
//   a_ready   in   1      lane A consumer takes head
//   b_data    out  WIDTH  lane B head word
//   b_valid   out  1      lane B non-empty
//   b_ready   in   1      lane B consumer takes head
//   a_count   out  CNT_W  words popped from lane A (stats build only)
//   b_count   out  CNT_W  words popped from lane B (stats build only)
// -----------------------------------------------------------------------------
module demux2way16_router
    import demux_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready
`ifdef DEMUX2WAY16_STATS_EN
    ,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
`endif
);

    logic a_full;
    logic b_full;
    logic a_push;
    logic b_push;
    logic a_pop;
    logic b_pop;

    // in_ready looks only at the selected lane's registered fullness; a pop on
    // a full lane in the same cycle does not open a slot until the next cycle.
    assign in_ready = (in_sel == LANE_B) ? ~b_full : ~a_full;

    assign a_push = in_valid & (in_sel == LANE_A) & ~a_full;
    assign b_push = in_valid & (in_sel == LANE_B) & ~b_full;

    assign a_pop  = a_valid & a_ready;
    assign b_pop  = b_valid & b_ready;

    demux_lane_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_lane_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (a_push),
        .push_data (in_data),
        .full      (a_full),
        .valid     (a_valid),
        .data      (a_data),
        .pop       (a_pop)
    );

    demux_lane_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_lane_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (b_push),
        .push_data (in_data),
        .full      (b_full),
        .valid     (b_valid),
        .data      (b_data),
        .pop       (b_pop)
    );

`ifdef DEMUX2WAY16_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Free-running pop counters; natural wrap at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_count <= '0;
            b_count <= '0;
        end else begin
            if (a_pop) begin
                a_count <= a_count + CNT_ONE;
            end
            if (b_pop) begin
                b_count <= b_count + CNT_ONE;
            end
        end
    end
`endif

endmodule : demux2way16_router

// File: tb/tb_demux2way16_router.sv
// -----------------------------------------------------------------------------
// tb_demux2way16_router
// Directed bench for demux2way16_router, plus a short randomised stretch
// compared against per-lane reference queues. Stats checks are compiled in
// when DEMUX2WAY16_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_demux2way16_router;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a_data;
    logic        a_valid;
    logic        a_ready;
    logic [15:0] b_data;
    logic        b_valid;
    logic        b_ready;
`ifdef DEMUX2WAY16_STATS_EN
    logic [15:0] a_count;
    logic [15:0] b_count;
`endif

    int passed = 0;
    int total  = 0;

    logic [15:0] qa[$];
    logic [15:0] qb[$];

    always #5 clk = ~clk;

    demux2way16_router dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready)
`ifdef DEMUX2WAY16_STATS_EN
        ,
        .a_count  (a_count),
        .b_count  (b_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one edge, then let outputs settle before the next drive/sample.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic s, input logic [15:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        #1;
    endtask

    initial begin
        logic        exp_ready;
        logic        ra;
        logic        rb;

        reset_n  = 1'b0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        drive(1'b1, 1'b0, 16'h5555);

        // Reset with in_valid held high
        tick();
        tick();
        check("rst_a_valid", {31'd0, a_valid}, 32'd0);
        check("rst_b_valid", {31'd0, b_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_a_data", {16'd0, a_data}, 32'd0);
        check("rst_b_data", {16'd0, b_data}, 32'd0);
`ifdef DEMUX2WAY16_STATS_EN
        check("rst_a_count", {16'd0, a_count}, 32'd0);
        check("rst_b_count", {16'd0, b_count}, 32'd0);
`endif
        drive(1'b0, 1'b0, 16'h0000);
        reset_n = 1'b1;
        tick();

        // Routing
        a_ready = 1'b1;
        b_ready = 1'b1;
        drive(1'b1, 1'b0, 16'h1234);
        check("route_a_ready", {31'd0, in_ready}, 32'd1);
        check("route_a_pre_valid", {31'd0, a_valid}, 32'd0);
        tick();
        check("route_a_valid", {31'd0, a_valid}, 32'd1);
        check("route_a_data", {16'd0, a_data}, 32'h1234);
        check("route_b_idle", {31'd0, b_valid}, 32'd0);
        drive(1'b1, 1'b1, 16'hABCD);
        check("route_b_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("route_a_gone", {31'd0, a_valid}, 32'd0);
        check("route_b_valid", {31'd0, b_valid}, 32'd1);
        check("route_b_data", {16'd0, b_data}, 32'hABCD);
        drive(1'b0, 1'b0, 16'h0000);
        tick();
        check("route_b_gone", {31'd0, b_valid}, 32'd0);

        // Full lane A
        a_ready = 1'b0;
        b_ready = 1'b0;
        drive(1'b1, 1'b0, 16'h0001);
        tick();
        drive(1'b1, 1'b0, 16'h0002);
        tick();
        drive(1'b1, 1'b0, 16'h0003);
        check("full_a_in_ready", {31'd0, in_ready}, 32'd0);
        drive(1'b1, 1'b1, 16'hBBBB);
        check("full_b_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("full_b_valid", {31'd0, b_valid}, 32'd1);
        check("full_b_data", {16'd0, b_data}, 32'hBBBB);
        a_ready = 1'b1;
        drive(1'b1, 1'b0, 16'h0003);
        check("full_pop_no_pass", {31'd0, in_ready}, 32'd0);
        check("full_head1", {16'd0, a_data}, 32'h0001);
        tick();
        check("full_head2", {16'd0, a_data}, 32'h0002);
        check("full_slot_ready", {31'd0, in_ready}, 32'd1);
        // Push + pop together in PARTIAL: occupancy stays 1
        tick();
        check("simul_valid", {31'd0, a_valid}, 32'd1);
        check("simul_head3", {16'd0, a_data}, 32'h0003);
        drive(1'b0, 1'b0, 16'h0000);
        tick();
        check("simul_drained", {31'd0, a_valid}, 32'd0);
        b_ready = 1'b1;
        tick();
        check("b_drained", {31'd0, b_valid}, 32'd0);

        // Randomised traffic against reference queues
        qa.delete();
        qb.delete();
        for (int i = 0; i < 100; i++) begin
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            a_ready = ra;
            b_ready = rb;
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
            exp_ready = in_sel ? (qb.size() < 2) : (qa.size() < 2);
            check("rnd_in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
            check("rnd_a", {15'd0, a_valid, (a_valid ? a_data : 16'd0)},
                  {15'd0, (qa.size() != 0), ((qa.size() != 0) ? qa[0] : 16'd0)});
            check("rnd_b", {15'd0, b_valid, (b_valid ? b_data : 16'd0)},
                  {15'd0, (qb.size() != 0), ((qb.size() != 0) ? qb[0] : 16'd0)});
            // Model the edge: pops use pre-edge occupancy, push only if ready.
            if (ra && qa.size() != 0) void'(qa.pop_front());
            if (rb && qb.size() != 0) void'(qb.pop_front());
            if (in_valid && exp_ready) begin
                if (in_sel) qb.push_back(in_data);
                else        qa.push_back(in_data);
            end
            tick();
        end
        drive(1'b0, 1'b0, 16'h0000);
        a_ready = 1'b1;
        b_ready = 1'b1;
        tick();
        tick();
        tick();
        check("rnd_drain_a", {31'd0, a_valid}, 32'd0);
        check("rnd_drain_b", {31'd0, b_valid}, 32'd0);

        // Reset with both lanes full
        a_ready = 1'b0;
        b_ready = 1'b0;
        drive(1'b1, 1'b0, 16'h0011); tick();
        drive(1'b1, 1'b0, 16'h0022); tick();
        drive(1'b1, 1'b1, 16'h0033); tick();
        drive(1'b1, 1'b1, 16'h0044); tick();
        drive(1'b1, 1'b0, 16'h0000);
        check("mid_a_full", {31'd0, in_ready}, 32'd0);
        drive(1'b1, 1'b1, 16'h0000);
        check("mid_b_full", {31'd0, in_ready}, 32'd0);
        drive(1'b0, 1'b0, 16'h0000);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("mid_a_valid", {31'd0, a_valid}, 32'd0);
        check("mid_b_valid", {31'd0, b_valid}, 32'd0);
        check("mid_a_data", {16'd0, a_data}, 32'd0);
        drive(1'b1, 1'b0, 16'h0055);
        tick();
        check("refill_a_data", {16'd0, a_data}, 32'h0055);
        drive(1'b0, 1'b0, 16'h0000);
        a_ready = 1'b1;
        tick();
        check("refill_no_stale", {31'd0, a_valid}, 32'd0);

`ifdef DEMUX2WAY16_STATS_EN
        // Counter wrap: one push-only edge, then 65535 push+pop edges.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("stat_rst_a", {16'd0, a_count}, 32'd0);
        a_ready = 1'b1;
        b_ready = 1'b0;
        drive(1'b1, 1'b0, 16'h7777);
        for (int i = 0; i < 65536; i++) begin
            @(posedge clk);
        end
        #2;
        check("stat_a_ffff", {16'd0, a_count}, 32'hFFFF);
        drive(1'b0, 1'b0, 16'h0000);
        tick();
        check("stat_a_wrap", {16'd0, a_count}, 32'd0);
        check("stat_b_hold", {16'd0, b_count}, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_demux2way16_router
